muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Multi-cycle RV32M execution unit in the execute stage, alongside the integer ALU.
- Consumes forwarded operands and func3 from the ID/EX register when the decoded opcode is OP with func7 = 0000001.
- Produces the 32-bit M-extension result and a busy flag that the hazard unit uses to stall IF/ID/EX.
- Multiplies take a fixed short latency. Divides use a 32-iteration restoring radix-2 datapath with single-cycle fast paths for the special cases.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; the iteration counter is sized from it.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when the unit can accept
- flush  input  1  kill the in-flight operation (branch mispredict or trap)
- func3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  input  32  rs1 value (multiplicand / dividend)
- op_b  input  32  rs2 value (multiplier / divisor)
- busy  output  1  operation in flight; stall request to the pipeline
- done  output  1  one-cycle pulse; result valid this cycle
- result  output  32  result; holds its last value until the next accepted start

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, result=0, counter=0, all datapath registers 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Accept rule: start is accepted only in IDLE or DONE, and only when flush=0. At acceptance, func3, op_a and op_b are registered. start in MUL/DIV/FIX is ignored.
- Acceptance into MUL (func3[2]=0):
  - Operands are registered as 33-bit values. op_a is sign-extended for MULH/MULHSU; op_b is sign-extended for MULH only.
  - MUL state forms the 66-bit product.
  - MUL selects bits [31:0]; the others select bits [63:32]. The selection is loaded into result.
  - Next state is DONE.
- Acceptance into DIV, normal case (func3[2]=1):
  - Record the signs: signed ops only, quotient sign = a^b, remainder sign = a.
  - Load magnitudes and set counter=31; next state DIV.
- DIV state, each cycle:
  - rem = {rem[30:0], dvd[31]}; subtract divisor.
  - If the difference is non-negative, keep it and shift in a quotient bit of 1; otherwise shift in 0.
  - Decrement counter. At counter==0, go to FIX.
- FIX: negate quotient or remainder per the recorded sign, select by func3[1] (0 = quotient, 1 = remainder), load result, go to DONE.
- Fast path (decided at acceptance, next state DONE, result loaded directly):
  - Divisor 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF, DIV/REM): DIV gives 0x80000000; REM gives 0.
- DONE: done=1 and busy=0 for exactly one cycle. Next state is IDLE, or the new op if start is accepted in this cycle.
- busy=1 in MUL, DIV and FIX, and is registered from the next state. It rises the cycle after acceptance and falls in the DONE cycle.
- Latency (done cycles after the accepting edge):
  - multiply: 2
  - divide: 34
  - fast path: 1
- flush:
  - In any state, the next state is IDLE and done stays 0 next cycle.
  - result is not updated.
  - flush overrides a simultaneous start.
- Async reset mid-operation: immediate return to the reset values listed above; no done pulse.
- Arithmetic is modulo 2^32 on results. Quotient and remainder negation are two's complement.
- The RISC-V identity holds: dividend = quotient*divisor + remainder, with the remainder taking the dividend's sign.

Test Plan:
- Multiply results, each done exactly 2 cycles after start:
  - MUL 7 × 0xFFFFFFFD → 0xFFFFFFEB
  - MULH 0x80000000 × 0x80000000 → 0x40000000
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF
- Divide results, done at cycle 34, busy high for exactly 33 cycles:
  - DIV 0xFFFFFFF9/2 → 0xFFFFFFFD
  - REM 0xFFFFFFF9/2 → 0xFFFFFFFF
  - DIVU 100/7 → 14
  - REMU 100/7 → 2
- Fast paths, done at cycle 1, busy never high:
  - DIV 5/0 → 0xFFFFFFFF
  - REMU 5/0 → 5
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000
  - REM of the same operands → 0
- Flush and ignored start:
  - Assert flush during the 10th DIV iteration → busy low next cycle, no done pulse, result unchanged.
  - A start asserted during DIV is ignored.
- Back-to-back: start a new MUL in the DONE cycle of a DIV → the DIV done pulses once, then the MUL done pulses 2 cycles later with the correct product.
- Async reset mid-divide: assert rst between clock edges → busy, done and result are 0 immediately. After release, a fresh DIVU 9/3 returns 3.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute stage and the RV32M unit.
// The pipeline side drives the request; the unit drives busy/done/result.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      func3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, flush, func3, op_a, op_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, func3, op_a, op_b,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle RV32M execution unit: short fixed-latency multiply, 32-step
// restoring divide, and single-cycle answers for divide-by-zero and the
// signed-overflow divide. busy stalls the front of the pipeline while an
// operation is in flight; done pulses for one cycle with the result.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_unit_if.slave bus
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_nextState;

    // Registered request and datapath state
    logic [2:0]      r_func3;
    logic [XLEN:0]   r_opA;
    logic [XLEN:0]   r_opB;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvd;
    logic [CW-1:0]   r_counter;
    logic            r_negQ;
    logic            r_negR;
    logic [XLEN-1:0] r_result;
    logic            r_busy;
    logic            r_done;

    // Combinational helpers
    logic            w_accept;
    logic            w_signedDiv;
    logic            w_divZero;
    logic            w_overflow;
    logic            w_fast;
    logic [XLEN-1:0] w_fastResult;
    logic            w_negA;
    logic            w_negB;
    logic [XLEN-1:0] w_magA;
    logic [XLEN-1:0] w_magB;
    logic            w_mulSignA;
    logic            w_mulSignB;
    logic [2*XLEN-1:0] w_mulA;
    logic [2*XLEN-1:0] w_mulB;
    logic [2*XLEN-1:0] w_product;
    logic [XLEN-1:0] w_mulSel;
    logic [XLEN:0]   w_remShift;
    logic [XLEN:0]   w_diff;
    logic [XLEN-1:0] w_remNext;
    logic [XLEN-1:0] w_dvdNext;
    logic [XLEN-1:0] w_fixResult;
    logic            w_busyNext;
    logic            w_doneNext;

    // State register; reset returns the unit to IDLE at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic; flush beats everything, including a new start
    always_comb begin
        w_nextState = r_state;
        if (bus.flush) begin
            w_nextState = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        if (!bus.func3[2]) begin
                            w_nextState = S_MUL;
                        end else if (w_fast) begin
                            w_nextState = S_DONE;
                        end else begin
                            w_nextState = S_DIV;
                        end
                    end else begin
                        w_nextState = S_IDLE;
                    end
                end
                S_MUL:   w_nextState = S_DONE;
                S_DIV:   w_nextState = (r_counter == '0) ? S_FIX : S_DIV;
                S_FIX:   w_nextState = S_DONE;
                default: w_nextState = S_IDLE;
            endcase
        end
    end

    // Output/datapath combinational logic: acceptance decode, product,
    // one restoring-divide step and the final sign fix-up
    always_comb begin
        w_accept     = ((r_state == S_IDLE) || (r_state == S_DONE)) && !bus.flush && bus.start;
        w_signedDiv  = !bus.func3[0];
        w_divZero    = (bus.op_b == '0);
        w_overflow   = w_signedDiv && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
        w_fast       = bus.func3[2] && (w_divZero || w_overflow);

        if (w_divZero) begin
            w_fastResult = bus.func3[1] ? bus.op_a : '1;
        end else begin
            w_fastResult = bus.func3[1] ? '0 : MIN_NEG;
        end

        w_negA = w_signedDiv && bus.op_a[XLEN-1];
        w_negB = w_signedDiv && bus.op_b[XLEN-1];
        w_magA = w_negA ? -bus.op_a : bus.op_a;
        w_magB = w_negB ? -bus.op_b : bus.op_b;

        w_mulSignA = ((bus.func3[1:0] == 2'b01) || (bus.func3[1:0] == 2'b10)) && bus.op_a[XLEN-1];
        w_mulSignB = (bus.func3[1:0] == 2'b01) && bus.op_b[XLEN-1];

        w_mulA    = {{(XLEN-1){r_opA[XLEN]}}, r_opA};
        w_mulB    = {{(XLEN-1){r_opB[XLEN]}}, r_opB};
        w_product = w_mulA * w_mulB;
        w_mulSel  = (r_func3 == 3'b000) ? w_product[XLEN-1:0] : w_product[2*XLEN-1:XLEN];

        w_remShift = {r_rem, r_dvd[XLEN-1]};
        w_diff     = w_remShift - {1'b0, r_opB[XLEN-1:0]};
        w_remNext  = w_diff[XLEN] ? w_remShift[XLEN-1:0] : w_diff[XLEN-1:0];
        w_dvdNext  = {r_dvd[XLEN-2:0], ~w_diff[XLEN]};

        if (r_func3[1]) begin
            w_fixResult = r_negR ? -r_rem : r_rem;
        end else begin
            w_fixResult = r_negQ ? -r_dvd : r_dvd;
        end

        w_busyNext = (w_nextState == S_MUL) || (w_nextState == S_DIV) || (w_nextState == S_FIX);
        w_doneNext = (w_nextState == S_DONE);
    end

    // Datapath registers: capture on acceptance, iterate while busy,
    // and load result only when an operation actually completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_func3   <= '0;
            r_opA     <= '0;
            r_opB     <= '0;
            r_rem     <= '0;
            r_dvd     <= '0;
            r_counter <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
            r_result  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_busy <= w_busyNext;
            r_done <= w_doneNext;
            if (w_accept) begin
                r_func3 <= bus.func3;
                if (!bus.func3[2]) begin
                    r_opA <= {w_mulSignA, bus.op_a};
                    r_opB <= {w_mulSignB, bus.op_b};
                end else if (w_fast) begin
                    r_result <= w_fastResult;
                end else begin
                    r_opB     <= {1'b0, w_magB};
                    r_dvd     <= w_magA;
                    r_rem     <= '0;
                    r_negQ    <= w_negA ^ w_negB;
                    r_negR    <= w_negA;
                    r_counter <= CW'(XLEN - 1);
                end
            end else if (!bus.flush) begin
                case (r_state)
                    S_MUL: begin
                        r_result <= w_mulSel;
                    end
                    S_DIV: begin
                        r_rem <= w_remNext;
                        r_dvd <= w_dvdNext;
                        if (r_counter != '0) begin
                            r_counter <= r_counter - 1'b1;
                        end
                    end
                    S_FIX: begin
                        r_result <= w_fixResult;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: every issued operation pushes its
// expected result, latency and busy length; a monitor thread pops and
// compares whenever done pulses.
module tb_muldiv_unit;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  f;
        int          issueCyc;
        int          lat;
        int          busySnap;
        int          busyCycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    muldiv_unit_if #(.XLEN(32)) bus();

    muldiv_unit #(.XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int cyc = 0;

    // Cycle counter used to measure done latency
    always @(posedge clk) cyc <= cyc + 1;

    int   checks    = 0;
    int   failures  = 0;
    int   busyTotal = 0;
    bit   stimDone  = 1'b0;
    exp_t sbQ[$];

    // Reference model straight from the RV32M rules using wide arithmetic
    function automatic logic [31:0] refModel(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        longint      p;
        logic [63:0] up;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit isFast(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] pickOperand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    // Drive one request for a single edge; optionally register its expectation
    task automatic applyStimulus(logic [2:0] f, logic [31:0] a, logic [31:0] b, bit expectDone);
        exp_t e;
        bus.func3 = f;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        if (expectDone) begin
            e.res      = refModel(f, a, b);
            e.f        = f;
            e.issueCyc = cyc;
            e.busySnap = busyTotal;
            if (!f[2]) begin
                e.lat = 2;  e.busyCycles = 1;
            end else if (isFast(f, a, b)) begin
                e.lat = 1;  e.busyCycles = 0;
            end else begin
                e.lat = 34; e.busyCycles = 33;
            end
            sbQ.push_back(e);
        end
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    // Bounded wait for done; leaves the caller at the negedge of the done cycle
    task automatic waitDone(string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.done && n < 100);
        checkOutput({name, " done seen"}, {31'b0, bus.done}, 32'h1);
    endtask

    task automatic runOp(logic [2:0] f, logic [31:0] a, logic [31:0] b, string name);
        applyStimulus(f, a, b, 1'b1);
        waitDone(name);
        @(negedge clk);
    endtask

    initial begin
        fork
            // Monitor: compare each done pulse against the scoreboard head
            begin : monitorThread
                exp_t e;
                while (!stimDone) begin
                    @(negedge clk);
                    if (bus.busy) busyTotal++;
                    if (bus.done) begin
                        checkOutput("busy low during done", {31'b0, bus.busy}, 32'h0);
                        if (sbQ.size() == 0) begin
                            checks++;
                            failures++;
                            $display("[TB] FAIL unexpected done actual=result 0x%08h required=no done pulse", bus.result);
                        end else begin
                            e = sbQ.pop_front();
                            checkOutput($sformatf("result f3=%0d", e.f), bus.result, e.res);
                            checkOutput($sformatf("latency f3=%0d", e.f), 32'(cyc - e.issueCyc), 32'(e.lat));
                            checkOutput($sformatf("busy cycles f3=%0d", e.f), 32'(busyTotal - e.busySnap), 32'(e.busyCycles));
                        end
                    end
                end
            end

            // Stimulus: directed cases from the test plan, then random traffic
            begin : stimThread
                logic [2:0]  rf;
                logic [31:0] ra;
                logic [31:0] rb;
                rst       = 1'b1;
                bus.start = 1'b0;
                bus.flush = 1'b0;
                bus.func3 = 3'd0;
                bus.op_a  = 32'h0;
                bus.op_b  = 32'h0;
                #1;
                checkOutput("reset busy",   {31'b0, bus.busy}, 32'h0);
                checkOutput("reset done",   {31'b0, bus.done}, 32'h0);
                checkOutput("reset result", bus.result, 32'h0);
                repeat (2) @(negedge clk);
                rst = 1'b0;
                @(negedge clk);

                $display("[TB] directed multiplies");
                runOp(3'd0, 32'd7,         32'hFFFF_FFFD, "MUL");
                runOp(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH");
                runOp(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU");
                runOp(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU");

                $display("[TB] directed divides and fast paths");
                runOp(3'd4, 32'hFFFF_FFF9, 32'd2,         "DIV");
                runOp(3'd6, 32'hFFFF_FFF9, 32'd2,         "REM");
                runOp(3'd7, 32'd100,       32'd7,         "REMU");
                runOp(3'd4, 32'd5,         32'd0,         "DIV by zero");
                runOp(3'd7, 32'd5,         32'd0,         "REMU by zero");
                runOp(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV overflow");
                runOp(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "REM overflow");
                runOp(3'd5, 32'd100,       32'd7,         "DIVU");

                $display("[TB] flush during the 10th divide iteration");
                applyStimulus(3'd4, 32'd1000, 32'd3, 1'b0);
                repeat (9) @(posedge clk);
                @(negedge clk);
                checkOutput("busy before flush", {31'b0, bus.busy}, 32'h1);
                bus.flush = 1'b1;
                @(posedge clk);
                #1 bus.flush = 1'b0;
                checkOutput("busy after flush",   {31'b0, bus.busy}, 32'h0);
                checkOutput("done after flush",   {31'b0, bus.done}, 32'h0);
                checkOutput("result after flush", bus.result, 32'd14);
                repeat (40) @(negedge clk);

                $display("[TB] start during divide is ignored, then back-to-back multiply");
                applyStimulus(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1);
                repeat (5) @(negedge clk);
                bus.func3 = 3'd0;
                bus.op_a  = 32'd3;
                bus.op_b  = 32'd5;
                bus.start = 1'b1;
                @(negedge clk);
                bus.start = 1'b0;
                waitDone("DIV with ignored start");
                applyStimulus(3'd0, 32'h0001_2345, 32'h0000_0010, 1'b1);
                waitDone("back-to-back MUL");
                @(negedge clk);

                $display("[TB] async reset mid-divide");
                applyStimulus(3'd5, 32'h0000_FFFF, 32'd3, 1'b0);
                repeat (5) @(negedge clk);
                #2 rst = 1'b1;
                #1;
                checkOutput("async reset busy",   {31'b0, bus.busy}, 32'h0);
                checkOutput("async reset done",   {31'b0, bus.done}, 32'h0);
                checkOutput("async reset result", bus.result, 32'h0);
                @(negedge clk);
                rst = 1'b0;
                @(negedge clk);
                runOp(3'd5, 32'd9, 32'd3, "DIVU after reset");

                $display("[TB] random traffic");
                for (int i = 0; i < 40; i++) begin
                    rf = 3'($urandom_range(0, 7));
                    ra = pickOperand();
                    rb = pickOperand();
                    applyStimulus(rf, ra, rb, 1'b1);
                    waitDone($sformatf("random op %0d", i));
                    if ($urandom_range(0, 1) == 1) @(negedge clk);
                end

                repeat (3) @(negedge clk);
                stimDone = 1'b1;
            end
        join

        checkOutput("scoreboard drained", 32'(sbQ.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
